// File: rtl/fir_complex_decim.sv
// Complex-coefficient FIR with decimation: collects DECIMATION_FACTOR samples,
// then runs TAP_COUNT/MULT_PER_CYCLE MAC cycles and presents one saturated result.
module fir_complex_decim #(
  parameter int unsigned TAP_COUNT         = 8,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned MULT_PER_CYCLE    = 2,
  parameter int unsigned DECIMATION_FACTOR = 8,
  parameter int unsigned FRAC_BITS         = 10
) (
  input  logic                                                clock,
  input  logic                                                reset,
  input  logic signed [DATA_WIDTH-1:0]                        Iin,
  input  logic signed [DATA_WIDTH-1:0]                        Qin,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic                                                coef_wr_en,
  input  logic [(TAP_COUNT > 1 ? $clog2(TAP_COUNT) : 1)-1:0]  coef_addr,
  input  logic signed [DATA_WIDTH-1:0]                        coef_I,
  input  logic signed [DATA_WIDTH-1:0]                        coef_Q,
  output logic signed [DATA_WIDTH-1:0]                        Iout,
  output logic signed [DATA_WIDTH-1:0]                        Qout,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic                                                sat
);

  localparam int unsigned AW    = (TAP_COUNT > 1) ? $clog2(TAP_COUNT) : 1;
  localparam int unsigned ACC_W = 2 * DATA_WIDTH + $clog2(TAP_COUNT) + 1;
  localparam int unsigned PW    = 2 * DATA_WIDTH;
  localparam int unsigned STEPS = TAP_COUNT / MULT_PER_CYCLE;
  localparam int unsigned SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned DCW   = (DECIMATION_FACTOR > 1) ? $clog2(DECIMATION_FACTOR) : 1;

  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;

  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] xi [TAP_COUNT];
  logic signed [DATA_WIDTH-1:0] xq [TAP_COUNT];
  logic signed [DATA_WIDTH-1:0] ci [TAP_COUNT];
  logic signed [DATA_WIDTH-1:0] cq [TAP_COUNT];

  logic signed [ACC_W-1:0]      acc_i, acc_q, acc_i_nxt, acc_q_nxt, sh_i, sh_q;
  logic signed [PW-1:0]         p_ii, p_qq, p_iq, p_qi;
  logic signed [DATA_WIDTH-1:0] res_i, res_q;
  logic                         clip;
  logic [AW-1:0]                tap;
  logic [SW-1:0]                step;
  logic [DCW-1:0]               dcnt;
  logic                         accept, trigger, last_step;

  assign accept    = in_valid && (state == IDLE);
  assign trigger   = accept && (dcnt == DCW'(DECIMATION_FACTOR - 1));
  assign last_step = (step == SW'(STEPS - 1));

  // FSM state register; in_ready tracks the next state so it is a flop output
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger)   state_nxt = COMPUTE;
      COMPUTE: if (last_step) state_nxt = OUTPUT;
      OUTPUT:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // MAC over MULT_PER_CYCLE consecutive taps of the current step
  always_comb begin
    acc_i_nxt = acc_i;
    acc_q_nxt = acc_q;
    tap  = '0;
    p_ii = '0;
    p_qq = '0;
    p_iq = '0;
    p_qi = '0;
    for (int m = 0; m < int'(MULT_PER_CYCLE); m++) begin
      tap  = AW'(32'(step) * MULT_PER_CYCLE + 32'(m));
      p_ii = PW'(ci[tap]) * PW'(xi[tap]);
      p_qq = PW'(cq[tap]) * PW'(xq[tap]);
      p_iq = PW'(ci[tap]) * PW'(xq[tap]);
      p_qi = PW'(cq[tap]) * PW'(xi[tap]);
      acc_i_nxt = acc_i_nxt + ACC_W'(p_ii) - ACC_W'(p_qq);
      acc_q_nxt = acc_q_nxt + ACC_W'(p_iq) + ACC_W'(p_qi);
    end
  end

  // Rescale (floor) and clip to the output width
  always_comb begin
    sh_i  = acc_i_nxt >>> FRAC_BITS;
    sh_q  = acc_q_nxt >>> FRAC_BITS;
    res_i = DATA_WIDTH'(sh_i);
    res_q = DATA_WIDTH'(sh_q);
    clip  = 1'b0;
    if (sh_i > SMAX) begin res_i = DATA_WIDTH'(SMAX); clip = 1'b1; end
    if (sh_i < SMIN) begin res_i = DATA_WIDTH'(SMIN); clip = 1'b1; end
    if (sh_q > SMAX) begin res_q = DATA_WIDTH'(SMAX); clip = 1'b1; end
    if (sh_q < SMIN) begin res_q = DATA_WIDTH'(SMIN); clip = 1'b1; end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < int'(TAP_COUNT); k++) begin
        xi[k] <= '0;
        xq[k] <= '0;
        ci[k] <= (k == 0) ? DATA_WIDTH'(64'd1 << FRAC_BITS) : '0;
        cq[k] <= '0;
      end
      acc_i     <= '0;
      acc_q     <= '0;
      step      <= '0;
      dcnt      <= '0;
      Iout      <= '0;
      Qout      <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        for (int k = int'(TAP_COUNT) - 1; k > 0; k--) begin
          xi[k] <= xi[k-1];
          xq[k] <= xq[k-1];
        end
        xi[0] <= Iin;
        xq[0] <= Qin;
        dcnt  <= trigger ? '0 : dcnt + DCW'(1);
      end
      if (coef_wr_en && (state == IDLE)) begin
        ci[coef_addr] <= coef_I;
        cq[coef_addr] <= coef_Q;
      end
      if (trigger) begin
        acc_i <= '0;
        acc_q <= '0;
        step  <= '0;
      end
      if (state == COMPUTE) begin
        acc_i <= acc_i_nxt;
        acc_q <= acc_q_nxt;
        step  <= step + SW'(1);
        if (last_step) begin
          Iout      <= res_i;
          Qout      <= res_q;
          sat       <= clip;
          out_valid <= 1'b1;
        end
      end
      if ((state == OUTPUT) && out_ready) out_valid <= 1'b0;
    end
  end

endmodule
